// File: rtl/sdram_arbiter_pkg.sv
// Shared types and widths for the loader/CPU SDRAM arbiter.
// Latency/backpressure: n/a (types only).
package sdram_arbiter_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD
  } state_t;

  typedef enum logic {
    GNT_MC,
    GNT_CPU
  } gnt_t;

endpackage

// File: rtl/sdram_arbiter_req_slot.sv
// One-deep request holder: latches a strobed request while empty, 1-cycle capture latency.
// A strobe arriving while the slot is full is dropped; full doubles as the requester's busy.
module sdram_req_slot
  import sdram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              write,
  input  logic              clr,
  output logic              full,
  output logic [ADDR_W-1:0] slot_address,
  output logic [DATA_W-1:0] slot_wdata,
  output logic              slot_write
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;

  // clr only ever targets a full slot, so it never races a capture.
  always_comb begin
    full_d  = full_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (!full_q && !req_n) begin
      full_d  = 1'b1;
      addr_d  = address;
      wdata_d = wdata;
      write_d = write;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign full         = full_q;
  assign slot_address = addr_q;
  assign slot_wdata   = wdata_q;
  assign slot_write   = write_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates loader and CPU slots onto one SDRAM command port; command 2 cycles after strobe.
// Command held until sdr_ready; reads wait up to RD_TIMEOUT cycles, then return FFh.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_freeze,
  input  logic [ADDR_W-1:0] mc_address,
  input  logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_req_n,
  output logic              mc_busy,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wr_n,
  input  logic              cpu_req_n,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdata_en,
  output logic [ADDR_W-1:0] sdr_address,
  output logic [DATA_W-1:0] sdr_wdata,
  output logic              sdr_write,
  output logic              sdr_valid,
  input  logic              sdr_ready,
  input  logic [DATA_W-1:0] sdr_rdata,
  input  logic              sdr_rdata_en,
  output logic              rd_timeout
);

  localparam logic [7:0] RD_LIM = 8'(RD_TIMEOUT);

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic [1:0]        starve_q, starve_d;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic              sdr_valid_q, sdr_valid_d;
  logic              sdr_write_q, sdr_write_d;
  logic [ADDR_W-1:0] sdr_address_q, sdr_address_d;
  logic [DATA_W-1:0] sdr_wdata_q, sdr_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rdata_en_q, cpu_rdata_en_d;
  logic              rd_timeout_q, rd_timeout_d;

  logic              mc_full, cpu_full;
  logic [ADDR_W-1:0] mc_addr_s, cpu_addr_s;
  logic [DATA_W-1:0] mc_wdata_s, cpu_wdata_s;
  logic              mc_write_s, cpu_write_s;
  logic              clr_gnt, pick_mc;

  sdram_req_slot u_mc_slot (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_n        (mc_req_n),
    .address      (mc_address),
    .wdata        (mc_wdata),
    .write        (1'b1),
    .clr          (clr_gnt && (gnt_q == GNT_MC)),
    .full         (mc_full),
    .slot_address (mc_addr_s),
    .slot_wdata   (mc_wdata_s),
    .slot_write   (mc_write_s)
  );

  sdram_req_slot u_cpu_slot (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_n        (cpu_req_n),
    .address      (cpu_address),
    .wdata        (cpu_wdata),
    .write        (~cpu_wr_n),
    .clr          (clr_gnt && (gnt_q == GNT_CPU)),
    .full         (cpu_full),
    .slot_address (cpu_addr_s),
    .slot_wdata   (cpu_wdata_s),
    .slot_write   (cpu_write_s)
  );

  // Loader wins when alone, when frozen, or after losing two contested rounds in a row.
  assign pick_mc = mc_full && (!cpu_full || cpu_freeze || (starve_q == 2'd2));

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    starve_d       = starve_q;
    rd_cnt_d       = rd_cnt_q;
    sdr_valid_d    = sdr_valid_q;
    sdr_write_d    = sdr_write_q;
    sdr_address_d  = sdr_address_q;
    sdr_wdata_d    = sdr_wdata_q;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_rdata_en_d = 1'b0;
    rd_timeout_d   = rd_timeout_q;
    clr_gnt        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mc_full || cpu_full) begin
          gnt_d = pick_mc ? GNT_MC : GNT_CPU;
          if (pick_mc)      starve_d = 2'd0;
          else if (mc_full) starve_d = starve_q + 2'd1;
          sdr_address_d = pick_mc ? mc_addr_s  : cpu_addr_s;
          sdr_wdata_d   = pick_mc ? mc_wdata_s : cpu_wdata_s;
          sdr_write_d   = pick_mc ? mc_write_s : cpu_write_s;
          sdr_valid_d   = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sdr_ready) begin
          sdr_valid_d = 1'b0;
          if (sdr_write_q) begin
            clr_gnt = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rd_cnt_d = 8'd0;
            state_d  = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (sdr_rdata_en) begin
          cpu_rdata_d    = sdr_rdata;
          cpu_rdata_en_d = 1'b1;
          clr_gnt        = 1'b1;
          state_d        = ST_IDLE;
        end else if (rd_cnt_q + 8'd1 == RD_LIM) begin
          cpu_rdata_d    = 8'hFF;
          cpu_rdata_en_d = 1'b1;
          rd_timeout_d   = 1'b1;
          clr_gnt        = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      gnt_q          <= GNT_MC;
      starve_q       <= 2'd0;
      rd_cnt_q       <= 8'd0;
      sdr_valid_q    <= 1'b0;
      sdr_write_q    <= 1'b0;
      sdr_address_q  <= '0;
      sdr_wdata_q    <= '0;
      cpu_rdata_q    <= '0;
      cpu_rdata_en_q <= 1'b0;
      rd_timeout_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      starve_q       <= starve_d;
      rd_cnt_q       <= rd_cnt_d;
      sdr_valid_q    <= sdr_valid_d;
      sdr_write_q    <= sdr_write_d;
      sdr_address_q  <= sdr_address_d;
      sdr_wdata_q    <= sdr_wdata_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_rdata_en_q <= cpu_rdata_en_d;
      rd_timeout_q   <= rd_timeout_d;
    end
  end

  assign mc_busy      = mc_full;
  assign cpu_busy     = cpu_full;
  assign sdr_valid    = sdr_valid_q;
  assign sdr_write    = sdr_write_q;
  assign sdr_address  = sdr_address_q;
  assign sdr_wdata    = sdr_wdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_rdata_en = cpu_rdata_en_q;
  assign rd_timeout   = rd_timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and random stimulus for sdram_arbiter, checked each cycle against a request-level model.
module tb_sdram_arbiter;

  localparam int RD_T = 8;

  logic        clk;
  logic        reset_n;
  logic        cpu_freeze;
  logic [21:0] mc_address;
  logic [7:0]  mc_wdata;
  logic        mc_req_n;
  logic        mc_busy;
  logic [21:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr_n;
  logic        cpu_req_n;
  logic        cpu_busy;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_en;
  logic [21:0] sdr_address;
  logic [7:0]  sdr_wdata;
  logic        sdr_write;
  logic        sdr_valid;
  logic        sdr_ready;
  logic [7:0]  sdr_rdata;
  logic        sdr_rdata_en;
  logic        rd_timeout;

  sdram_arbiter #(.RD_TIMEOUT(RD_T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_freeze   (cpu_freeze),
    .mc_address   (mc_address),
    .mc_wdata     (mc_wdata),
    .mc_req_n     (mc_req_n),
    .mc_busy      (mc_busy),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_wr_n     (cpu_wr_n),
    .cpu_req_n    (cpu_req_n),
    .cpu_busy     (cpu_busy),
    .cpu_rdata    (cpu_rdata),
    .cpu_rdata_en (cpu_rdata_en),
    .sdr_address  (sdr_address),
    .sdr_wdata    (sdr_wdata),
    .sdr_write    (sdr_write),
    .sdr_valid    (sdr_valid),
    .sdr_ready    (sdr_ready),
    .sdr_rdata    (sdr_rdata),
    .sdr_rdata_en (sdr_rdata_en),
    .rd_timeout   (rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Request-level reference: index 0 = loader, 1 = CPU; owner -1 means nothing in service.
  bit          m_full [2];
  logic [21:0] m_addr [2];
  logic [7:0]  m_data [2];
  bit          m_wr   [2];
  int          m_owner, m_acc_cyc, m_losses, cyc;
  bit          m_acc;
  logic        e_valid, e_write, e_rdata_en, e_to;
  logic [21:0] e_addr;
  logic [7:0]  e_wdata, e_rdata;

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_full[r] = 0; m_addr[r] = '0; m_data[r] = '0; m_wr[r] = 0;
    end
    m_owner = -1; m_acc = 0; m_acc_cyc = 0; m_losses = 0;
    e_valid = 0; e_write = 0; e_addr = '0; e_wdata = '0;
    e_rdata = '0; e_rdata_en = 0; e_to = 0;
  endtask

  function automatic logic [63:0] outs();
    return {20'd0, mc_busy, cpu_busy, sdr_valid, sdr_write, sdr_address, sdr_wdata,
            cpu_rdata, cpu_rdata_en, rd_timeout};
  endfunction

  function automatic logic [63:0] exp_outs();
    return {20'd0, m_full[0], m_full[1], e_valid, e_write, e_addr, e_wdata,
            e_rdata, e_rdata_en, e_to};
  endfunction

  task automatic model_update();
    bit   nfull [2];
    logic pulse;
    int   w;
    pulse = 0;
    nfull[0] = m_full[0];
    nfull[1] = m_full[1];
    if (m_owner < 0) begin
      if (m_full[0] || m_full[1]) begin
        if (m_full[0] && m_full[1]) w = (cpu_freeze || m_losses >= 2) ? 0 : 1;
        else                        w = m_full[0] ? 0 : 1;
        if (w == 0)         m_losses = 0;
        else if (m_full[0]) m_losses++;
        m_owner = w; m_acc = 0;
        e_addr = m_addr[w]; e_wdata = m_data[w]; e_write = m_wr[w];
      end
    end else if (!m_acc) begin
      if (sdr_ready) begin
        if (m_wr[m_owner]) begin
          nfull[m_owner] = 0; m_owner = -1;
        end else begin
          m_acc = 1; m_acc_cyc = cyc;
        end
      end
    end else if (sdr_rdata_en || (cyc - m_acc_cyc == RD_T)) begin
      e_rdata = sdr_rdata_en ? sdr_rdata : 8'hFF;
      if (!sdr_rdata_en) e_to = 1;
      pulse = 1;
      nfull[m_owner] = 0; m_owner = -1; m_acc = 0;
    end
    if (!m_full[0] && !mc_req_n) begin
      nfull[0] = 1; m_addr[0] = mc_address; m_data[0] = mc_wdata; m_wr[0] = 1;
    end
    if (!m_full[1] && !cpu_req_n) begin
      nfull[1] = 1; m_addr[1] = cpu_address; m_data[1] = cpu_wdata; m_wr[1] = !cpu_wr_n;
    end
    m_full[0] = nfull[0];
    m_full[1] = nfull[1];
    e_rdata_en = pulse;
    e_valid = (m_owner >= 0) && !m_acc;
    cyc++;
  endtask

  // Called just after a rising edge with inputs already set; returns just after the next edge.
  task automatic step();
    @(negedge clk);
    chk("cycle", outs(), exp_outs());
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mc_req_n = 1'b1; cpu_req_n = 1'b1; sdr_ready = 1'b0; sdr_rdata_en = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 chk("reset_async", outs(), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic serve_cmd(input string tag, input logic [21:0] exp_addr);
    int n = 0;
    while (!sdr_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, {sdr_valid, sdr_address}, {1'b1, exp_addr});
    sdr_ready = 1'b1;
    step();
    sdr_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, arb, mc_idx, cmds, pulses;
    logic [21:0] seen;
    reset_n = 1'b1; cpu_freeze = 1'b0; idle_in();
    mc_address = '0; mc_wdata = '0; cpu_address = '0; cpu_wdata = '0;
    cpu_wr_n = 1'b1; sdr_rdata = '0; cyc = 0; seen = '0;
    model_reset();
    #2 reset_n = 1'b0;
    #1 chk("reset_state", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Loader write with freeze, ready three cycles after the command appears.
    cpu_freeze = 1'b1; mc_address = 22'h048000; mc_wdata = 8'h5A; mc_req_n = 1'b0;
    step(); mc_req_n = 1'b1;
    step();
    chk("a_cmd", {sdr_valid, sdr_write, sdr_address, sdr_wdata}, {1'b1, 1'b1, 22'h048000, 8'h5A});
    repeat (3) step();
    chk("a_busy_at_ready", mc_busy, 1);
    sdr_ready = 1'b1; step(); sdr_ready = 1'b0;
    chk("a_busy_fall", mc_busy, 0);

    // CPU read, data four cycles after acceptance.
    cpu_freeze = 1'b0; cpu_address = 22'h000100; cpu_wr_n = 1'b1; cpu_req_n = 1'b0;
    step(); cpu_req_n = 1'b1;
    step();
    chk("b_cmd", {sdr_valid, sdr_write, sdr_address}, {1'b1, 1'b0, 22'h000100});
    sdr_ready = 1'b1; step(); sdr_ready = 1'b0;
    repeat (3) step();
    sdr_rdata = 8'hC3; sdr_rdata_en = 1'b1; step(); sdr_rdata_en = 1'b0;
    chk("b_rdata", {cpu_rdata_en, cpu_rdata, rd_timeout}, {1'b1, 8'hC3, 1'b0});
    step();
    chk("b_pulse_end", cpu_rdata_en, 0);

    // Simultaneous strobes: CPU first without freeze, loader first with freeze.
    mc_address = 22'h111111; cpu_address = 22'h222222; cpu_wr_n = 1'b0;
    mc_req_n = 1'b0; cpu_req_n = 1'b0;
    step(); mc_req_n = 1'b1; cpu_req_n = 1'b1;
    serve_cmd("c_first_cpu", 22'h222222);
    serve_cmd("c_second_mc", 22'h111111);
    cpu_freeze = 1'b1; mc_address = 22'h133333; cpu_address = 22'h244444;
    mc_req_n = 1'b0; cpu_req_n = 1'b0;
    step(); mc_req_n = 1'b1; cpu_req_n = 1'b1;
    serve_cmd("c_frz_first_mc", 22'h133333);
    serve_cmd("c_frz_second_cpu", 22'h244444);

    // Loader pending under a continuous CPU stream must not starve.
    cpu_freeze = 1'b0; mc_address = 22'h0AAAAA; cpu_address = 22'h155555; cpu_wr_n = 1'b0;
    mc_req_n = 1'b0; cpu_req_n = 1'b0; sdr_ready = 1'b1;
    step(); mc_req_n = 1'b1;
    arb = 0; mc_idx = 0;
    for (int i = 0; i < 30; i++) begin
      if (sdr_valid) begin
        arb++;
        if (sdr_address == 22'h0AAAAA && mc_idx == 0) mc_idx = arb;
      end
      step();
    end
    cpu_req_n = 1'b1;
    repeat (6) step();
    sdr_ready = 1'b0;
    chk("d_loader_grant_idx", (mc_idx >= 1 && mc_idx <= 3), 1);

    // Read with no data returned: FFh after the timeout, flag sticky.
    cpu_address = 22'h3ABCDE; cpu_wr_n = 1'b1; cpu_req_n = 1'b0;
    step(); cpu_req_n = 1'b1;
    serve_cmd("e_cmd", 22'h3ABCDE);
    n = 1;
    while (!cpu_rdata_en && n < 20) begin
      step();
      n++;
    end
    chk("e_to_delay", n, RD_T + 1);
    chk("e_to_data", {cpu_rdata_en, cpu_rdata, rd_timeout}, {1'b1, 8'hFF, 1'b1});
    repeat (5) step();
    chk("e_sticky", rd_timeout, 1);

    // Reset while a command is being offered; stray read data afterwards is ignored.
    cpu_freeze = 1'b1; mc_address = 22'h2468AC; mc_req_n = 1'b0;
    step(); mc_req_n = 1'b1;
    step();
    chk("f_valid_before_rst", sdr_valid, 1);
    do_reset();
    sdr_rdata_en = 1'b1; sdr_rdata = 8'h77;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_rdata_en) pulses++;
      step();
    end
    sdr_rdata_en = 1'b0;
    chk("f_no_pulse", pulses, 0);

    // Second strobe while the loader slot is busy yields only one command.
    mc_address = 22'h012345; mc_req_n = 1'b0;
    step();
    mc_address = 22'h3F0F0F;
    step(); mc_req_n = 1'b1;
    sdr_ready = 1'b1; cmds = 0;
    for (int i = 0; i < 12; i++) begin
      if (sdr_valid) begin
        cmds++;
        seen = sdr_address;
      end
      step();
    end
    sdr_ready = 1'b0;
    chk("f_single_cmd", cmds, 1);
    chk("f_cmd_addr", seen, 22'h012345);

    // Random traffic, including stray read data and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        idle_in();
        do_reset();
      end
      if ($urandom_range(0, 7) == 0) cpu_freeze = ~cpu_freeze;
      mc_req_n     = ($urandom_range(0, 3) != 0);
      mc_address   = 22'($urandom());
      mc_wdata     = 8'($urandom());
      cpu_req_n    = ($urandom_range(0, 2) != 0);
      cpu_address  = 22'($urandom());
      cpu_wdata    = 8'($urandom());
      cpu_wr_n     = 1'($urandom_range(0, 1));
      sdr_ready    = ($urandom_range(0, 2) == 0);
      sdr_rdata_en = ($urandom_range(0, 9) == 0);
      sdr_rdata    = 8'($urandom());
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: RD_TIMEOUT, default 255, maximum cycles to wait for read data after the read command is accepted (range 1..255).
REQ-002 Port: clk  input  1  system clock, 85.90908 MHz; the only clock.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: cpu_freeze  input  1  from micom_connect; 1 = loader has priority.
REQ-005 Ports, loader side: mc_address in 22, write address; mc_wdata in 8, write data; mc_req_n in 1, one-cycle low write strobe; mc_busy out 1, drives micom_connect sdram_busy.
REQ-006 Ports, CPU side: cpu_address in 22; cpu_wdata in 8; cpu_wr_n in 1, 0 = write; cpu_req_n in 1, one-cycle low strobe; cpu_busy out 1; cpu_rdata out 8; cpu_rdata_en out 1.
REQ-007 Ports, SDRAM side: sdr_address out 22; sdr_wdata out 8; sdr_write out 1; sdr_valid out 1; sdr_ready in 1, command accepted; sdr_rdata in 8; sdr_rdata_en in 1.
REQ-008 Port: rd_timeout out 1, sticky flag, set on read timeout.

Function
REQ-009 Capture: each requester SHALL have one pending slot; a low mc_req_n/cpu_req_n while the slot is empty latches address/data/direction (loader always write) and sets the slot; mc_busy/cpu_busy SHALL be 1 from the cycle after the strobe until the cycle after that request completes.
REQ-010 Strobe while own slot full SHALL be ignored (no change to slot, no error).
REQ-011 FSM states: IDLE, ISSUE, WAIT_RD.
REQ-012 IDLE: if any slot full, grant per REQ-013, drive sdr_* from granted slot, go to ISSUE next cycle with sdr_valid=1.
REQ-013 Priority when both slots full: cpu_freeze=1 -> loader; cpu_freeze=0 -> CPU, except the loader wins if it lost the previous 2 consecutive arbitrations (anti-starvation counter, 2 bits, cleared on loader grant).
REQ-014 cpu_freeze sampled only in IDLE at grant; change mid-transaction SHALL not affect the current grant.
REQ-015 ISSUE: sdr_valid and sdr_* held stable until sdr_ready=1; on the ready cycle, a write clears the granted slot and returns to IDLE; a read goes to WAIT_RD and clears its timeout counter.
REQ-016 WAIT_RD: on sdr_rdata_en=1, cpu_rdata<=sdr_rdata, cpu_rdata_en=1 for exactly one cycle, slot cleared, back to IDLE.
REQ-017 WAIT_RD: counter (8 bits) increments each cycle; when it reaches RD_TIMEOUT without sdr_rdata_en, cpu_rdata<=FFh, cpu_rdata_en pulses, rd_timeout set, slot cleared, IDLE.
REQ-018 sdr_rdata_en outside WAIT_RD SHALL be ignored.
REQ-019 Minimum write turnaround: strobe at cycle N, sdr_valid at N+2, completion at ready cycle R, busy low at R+1; back-to-back grants allowed with one IDLE cycle between.
REQ-020 sdr_valid SHALL be 0 in IDLE and WAIT_RD.

Reset
REQ-021 reset_n=0 SHALL asynchronously force: state IDLE, both slots empty, mc_busy=0, cpu_busy=0, sdr_valid=0, sdr_write=0, sdr_address=0, sdr_wdata=0, cpu_rdata=00h, cpu_rdata_en=0, rd_timeout=0, counters 0.
REQ-022 Reset mid-transaction SHALL abandon the transaction silently; no rdata_en pulse is generated.
REQ-023 rd_timeout SHALL clear only on reset.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the grant enum (GNT_MC, GNT_CPU), and address/data width constants (22, 8).
REQ-025 One sub-module, sdram_req_slot, SHALL be instantiated twice for the capture slots; arbitration/FSM stays in the top.

Verification
REQ-026 Loader write: cpu_freeze=1, mc_req_n pulse addr 048000h data 5Ah, sdr_ready after 3 cycles -> sdr_write=1, sdr_address=048000h, sdr_wdata=5Ah, mc_busy falls 1 cycle after ready.
REQ-027 CPU read: cpu_wr_n=1 addr 000100h, sdr_rdata=C3h with rdata_en 4 cycles after ready -> cpu_rdata=C3h, cpu_rdata_en one cycle, rd_timeout=0.
REQ-028 Contention: both strobes same cycle, cpu_freeze=0 -> CPU granted first, loader second; with cpu_freeze=1 -> loader first.
REQ-029 Starvation: CPU strobes continuously while loader pending, cpu_freeze=0 -> loader granted on the third arbitration.
REQ-030 Timeout: RD_TIMEOUT=8, read accepted, never rdata_en -> cpu_rdata=FFh pulse after 8 cycles, rd_timeout=1 sticky.
REQ-031 Reset during ISSUE with sdr_valid=1 -> all outputs at reset values immediately, no cpu_rdata_en afterwards; strobe while busy ignored (single SDRAM command observed).
